// File: rtl/alu_multicycle.sv
// Integer ALU: single-cycle logic/compare/shift ops plus iterative mul/div, valid/ready handshake.
// Latency 1 cycle for single-cycle ops, XLEN+1 for mul/div; result held in DONE until out_ready.
module alu_multicycle #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluOp,
    input  logic [XLEN-1:0] aluX,
    input  logic [XLEN-1:0] aluY,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluO
);

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_OR     = 5'h02;
    localparam logic [4:0] OP_XOR    = 5'h03;
    localparam logic [4:0] OP_AND    = 5'h04;
    localparam logic [4:0] OP_LTU    = 5'h05;
    localparam logic [4:0] OP_LTS    = 5'h06;
    localparam logic [4:0] OP_SRL    = 5'h07;
    localparam logic [4:0] OP_SRA    = 5'h08;
    localparam logic [4:0] OP_SLL    = 5'h09;
    localparam logic [4:0] OP_GEU    = 5'h0B;
    localparam logic [4:0] OP_GES    = 5'h0C;
    localparam logic [4:0] OP_EQ     = 5'h0D;
    localparam logic [4:0] OP_NE     = 5'h0E;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHU  = 5'h12;
    localparam logic [4:0] OP_MULHSU = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] alu_o_q, alu_o_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;

    logic [SHW-1:0]  shamt;
    logic            is_mul, is_div, div_zero, div_ovf, iterative;
    logic            signed_x, signed_y;
    logic [XLEN-1:0] x_opnd, y_opnd;
    logic [XLEN-1:0] single_res;

    logic            op_q_is_mul;
    logic [XLEN:0]   sum_mul;
    logic [XLEN:0]   div_shift, div_trial;
    logic [XLEN-1:0] step_acc, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic [XLEN-1:0] calc_res;

    assign shamt    = aluY[SHW-1:0];
    assign is_mul   = (aluOp == OP_MUL) || (aluOp == OP_MULH) ||
                      (aluOp == OP_MULHU) || (aluOp == OP_MULHSU);
    assign is_div   = (aluOp == OP_DIV) || (aluOp == OP_DIVU) ||
                      (aluOp == OP_REM) || (aluOp == OP_REMU);
    assign div_zero = (aluY == '0);
    assign div_ovf  = ((aluOp == OP_DIV) || (aluOp == OP_REM)) &&
                      (aluX == {1'b1, {(XLEN-1){1'b0}}}) && (&aluY);
    // Zero divisor and signed overflow have fixed answers, so they skip the iterative path.
    assign iterative = is_mul || (is_div && !div_zero && !div_ovf);

    assign signed_x = (aluOp == OP_MULH) || (aluOp == OP_MULHSU) ||
                      (aluOp == OP_DIV) || (aluOp == OP_REM);
    assign signed_y = (aluOp == OP_MULH) || (aluOp == OP_DIV) || (aluOp == OP_REM);
    assign x_opnd   = (signed_x && aluX[XLEN-1]) ? (~aluX + 1'b1) : aluX;
    assign y_opnd   = (signed_y && aluY[XLEN-1]) ? (~aluY + 1'b1) : aluY;

    always_comb begin
        single_res = '0;
        case (aluOp)
            OP_ADD:  single_res = aluX + aluY;
            OP_SUB:  single_res = aluX - aluY;
            OP_OR:   single_res = aluX | aluY;
            OP_XOR:  single_res = aluX ^ aluY;
            OP_AND:  single_res = aluX & aluY;
            OP_LTU:  single_res = XLEN'(aluX < aluY);
            OP_LTS:  single_res = XLEN'($signed(aluX) < $signed(aluY));
            OP_SRL:  single_res = aluX >> shamt;
            OP_SRA:  single_res = $unsigned($signed(aluX) >>> shamt);
            OP_SLL:  single_res = aluX << shamt;
            OP_GEU:  single_res = XLEN'(aluX >= aluY);
            OP_GES:  single_res = XLEN'($signed(aluX) >= $signed(aluY));
            OP_EQ:   single_res = XLEN'(aluX == aluY);
            OP_NE:   single_res = XLEN'(aluX != aluY);
            OP_DIV:  single_res = div_zero ? '1 : aluX;
            OP_DIVU: single_res = '1;
            OP_REM:  single_res = div_zero ? aluX : '0;
            OP_REMU: single_res = aluX;
            default: single_res = '0;
        endcase
    end

    // One iteration: shift-add step for multiply, restoring-subtract step for divide.
    assign op_q_is_mul = (op_q[4:2] == 3'b100);
    assign sum_mul     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift   = {acc_q, lo_q[XLEN-1]};
    assign div_trial   = div_shift - {1'b0, b_q};

    always_comb begin
        step_acc = acc_q;
        step_lo  = lo_q;
        if (op_q_is_mul) begin
            step_acc = sum_mul[XLEN:1];
            step_lo  = {sum_mul[0], lo_q[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            step_acc = div_trial[XLEN-1:0];
            step_lo  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = div_shift[XLEN-1:0];
            step_lo  = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    assign prod     = {step_acc, step_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~step_lo + 1'b1) : step_lo;
    assign rem_fix  = neg_rem_q ? (~step_acc + 1'b1) : step_acc;

    always_comb begin
        calc_res = '0;
        case (op_q)
            OP_MUL:    calc_res = prod_fix[XLEN-1:0];
            OP_MULH,
            OP_MULHU,
            OP_MULHSU: calc_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   calc_res = quo_fix;
            OP_REM,
            OP_REMU:   calc_res = rem_fix;
            default:   calc_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alu_o_d   = alu_o_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (iterative) begin
                        op_d      = aluOp;
                        acc_d     = '0;
                        cnt_d     = '0;
                        neg_d     = (signed_x & aluX[XLEN-1]) ^ (signed_y & aluY[XLEN-1]);
                        neg_rem_d = signed_x & aluX[XLEN-1];
                        if (is_mul) begin
                            b_d  = x_opnd;
                            lo_d = y_opnd;
                        end else begin
                            b_d  = y_opnd;
                            lo_d = x_opnd;
                        end
                        state_d = CALC;
                    end else begin
                        alu_o_d = single_res;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    alu_o_d = calc_res;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_o_q   <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_o_q   <= alu_o_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign aluO      = alu_o_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at XLEN=32 and XLEN=64 with hand-computed results.
module tb_alu_multicycle;

    localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, OR_ = 5'h02, XOR_ = 5'h03, AND_ = 5'h04;
    localparam logic [4:0] LTU = 5'h05, LTS = 5'h06, SRL = 5'h07, SRA = 5'h08, SLL = 5'h09;
    localparam logic [4:0] GEU = 5'h0B, GES = 5'h0C, EQ = 5'h0D, NE = 5'h0E;
    localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHU = 5'h12, MULHSU = 5'h13;
    localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_o;

    logic        in_valid64, in_ready64, out_valid64;
    logic [4:0]  alu_op64;
    logic [63:0] alu_x64, alu_y64, alu_o64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(alu_op), .aluX(alu_x), .aluY(alu_y),
        .out_valid(out_valid), .out_ready(out_ready), .aluO(alu_o)
    );

    alu_multicycle #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .aluOp(alu_op64), .aluX(alu_x64), .aluY(alu_y64),
        .out_valid(out_valid64), .out_ready(1'b1), .aluO(alu_o64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles inputs while busy, then checks latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, " in_ready"}, 64'(in_ready), 64'(1));
        alu_op   = op;
        alu_x    = x;
        alu_y    = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            in_valid = 1'b1;
            alu_op   = 5'($urandom_range(0, 31));
            alu_x    = $urandom;
            alu_y    = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(alu_o), 64'(exp));
        @(posedge clk); #1;
        check({tag, " back idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    initial begin
        int lat64;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alu_op     = '0;
        alu_x      = '0;
        alu_y      = '0;
        in_valid64 = 1'b0;
        alu_op64   = '0;
        alu_x64    = '0;
        alu_y64    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset aluO", 64'(alu_o), 64'(0));
        check("reset64 state", 64'({in_ready64, out_valid64}), 64'(2'b10));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add wrap", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sub wrap", SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
        run_op("or", OR_, 32'hF0, 32'h0F, 32'hFF, 1);
        run_op("xor", XOR_, 32'hFF, 32'h0F, 32'hF0, 1);
        run_op("and", AND_, 32'hFF, 32'h0F, 32'h0F, 1);
        run_op("sra", SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        run_op("srl", SRL, 32'h8000_0000, 32'h1F, 32'h1, 1);
        run_op("sll", SLL, 32'h1, 32'h21, 32'h2, 1);
        run_op("lts", LTS, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("ltu", LTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("ges", GES, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("geu", GEU, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("eq", EQ, 32'h5, 32'h5, 32'h1, 1);
        run_op("ne", NE, 32'h5, 32'h5, 32'h0, 1);
        run_op("undef 0A", 5'h0A, 32'h1, 32'h1, 32'h0, 1);
        run_op("undef 1F", 5'h1F, 32'h1234, 32'h1, 32'h0, 1);

        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul", MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhsu neg x", MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
        run_op("mulhsu big y", MULHSU, 32'h2, 32'hFFFF_FFFF, 32'h1, 33);

        run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        run_op("div 7/-2", DIV, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem 7/-2", REM, 32'h7, 32'hFFFF_FFFE, 32'h1, 33);
        run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
        run_op("remu big", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("divu by 0", DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("remu by 0", REMU, 32'h5, 32'h0, 32'h5, 1);
        run_op("div by 0", DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Backpressure: result must hold while new requests are offered.
        out_ready = 1'b0;
        alu_op    = ADD;
        alu_x     = 32'd2;
        alu_y     = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        check("bp first valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            alu_op   = SUB;
            alu_x    = 32'd100;
            alu_y    = 32'd1;
            @(posedge clk); #1;
            check("bp hold valid", 64'(out_valid), 64'(1));
            check("bp hold aluO", 64'(alu_o), 64'(5));
            check("bp in_ready low", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release idle", 64'({in_ready, out_valid}), 64'(2'b10));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next accepted", 64'(out_valid), 64'(1));
        check("bp next result", 64'(alu_o), 64'(99));
        @(posedge clk); #1;

        // Reset in the middle of a divide.
        alu_op   = DIVU;
        alu_x    = 32'd1000;
        alu_y    = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("calc busy", 64'({in_ready, out_valid}), 64'(2'b00));
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'(0));
        check("abort aluO", 64'(alu_o), 64'(0));
        check("abort in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after abort idle", 64'(out_valid), 64'(0));
        run_op("add after rst", ADD, 32'd2, 32'd3, 32'd5, 1);

        // 64-bit instance.
        alu_op64   = MULHU;
        alu_x64    = 64'hFFFF_FFFF_FFFF_FFFF;
        alu_y64    = 64'h2;
        in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        lat64 = 1;
        while (!out_valid64 && lat64 < 300) begin
            @(posedge clk); #1;
            lat64++;
        end
        check("mulhu64 latency", 64'(lat64), 64'(65));
        check("mulhu64 result", alu_o64, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
